// File: rtl/ext_irq_ctrl.sv
// ext_irq_ctrl: machine-external interrupt controller.
// Synchronizes NUM_SRC asynchronous sources, latches per-source pending bits
// (edge or level triggered), masks them with ENABLE and drives one registered
// interrupt line to the core. Software claims the lowest-numbered enabled
// pending source through a read of 0x8 and releases it with a write of its ID
// to the same offset.
module ext_irq_ctrl #(
  parameter int unsigned NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [3:0]         addr,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ext_irq
);

  localparam logic [3:0] ADDR_ENABLE  = 4'h0;
  localparam logic [3:0] ADDR_PENDING = 4'h4;
  localparam logic [3:0] ADDR_CLAIM   = 4'h8;
  localparam logic [3:0] ADDR_TRIGGER = 4'hC;

  // Synchronizer and edge-detect history
  logic [NUM_SRC-1:0] sync1_q;
  logic [NUM_SRC-1:0] sync2_q;
  logic [NUM_SRC-1:0] sprev_q;

  // Architectural state
  logic [NUM_SRC-1:0] enable_q,  enable_d;
  logic [NUM_SRC-1:0] trigger_q, trigger_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] insvc_q,   insvc_d;
  logic [31:0]        rdata_q,   rdata_d;
  logic               ext_irq_q, ext_irq_d;

  // Decode and selection helpers
  logic               do_claim;
  logic               do_complete;
  logic [NUM_SRC-1:0] masked;
  logic [NUM_SRC-1:0] claim_oh;
  logic [NUM_SRC-1:0] claim_clr;
  logic [NUM_SRC-1:0] cmp_clr;
  logic [NUM_SRC-1:0] edge_det;
  logic [4:0]         claim_id;
  logic               found;

  // Only the low bits of wdata carry meaning for some offsets
  logic unused_wdata;
  assign unused_wdata = ^wdata;

  // Two-flop synchronizer plus the previous synchronized sample for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sprev_q <= '0;
    end else begin
      sync1_q <= irq_src;
      sync2_q <= sync1_q;
      sprev_q <= sync2_q;
    end
  end

  // Bus access decode for the claim/complete register
  always_comb begin
    do_claim    = rd_en && (addr == ADDR_CLAIM);
    do_complete = wr_en && (addr == ADDR_CLAIM);
  end

  // Lowest-index enabled pending source wins the claim
  always_comb begin
    masked   = pending_q & enable_q;
    claim_oh = '0;
    claim_id = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (masked[i] && !found) begin
        found       = 1'b1;
        claim_oh[i] = 1'b1;
        claim_id    = 5'(i + 1);
      end
    end
    claim_clr = do_claim ? claim_oh : '0;
  end

  // Complete clears in_service only for a legal ID whose source is in service
  always_comb begin
    cmp_clr = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (do_complete && (wdata[4:0] == 5'(i + 1)) && insvc_q[i]) begin
        cmp_clr[i] = 1'b1;
      end
    end
  end

  // Pending, in-service, control-register and interrupt-line next state
  always_comb begin
    edge_det  = sync2_q & ~sprev_q;
    enable_d  = enable_q;
    trigger_d = trigger_q;
    pending_d = pending_q;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (trigger_q[i]) begin
        // A new edge in the same cycle as a claim keeps the bit set
        pending_d[i] = (pending_q[i] & ~claim_clr[i]) | edge_det[i];
      end else begin
        pending_d[i] = ~insvc_q[i] & sync2_q[i] & ~claim_clr[i];
      end
    end
    // Complete is applied before the claim so a simultaneous claim of the
    // same source leaves it in service
    insvc_d = (insvc_q & ~cmp_clr) | claim_clr;
    if (wr_en && (addr == ADDR_ENABLE)) begin
      enable_d = wdata[NUM_SRC-1:0];
    end
    if (wr_en && (addr == ADDR_TRIGGER)) begin
      trigger_d = wdata[NUM_SRC-1:0];
    end
    ext_irq_d = |masked;
  end

  // Registered read data; holds while no read is issued
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      case (addr)
        ADDR_ENABLE:  rdata_d = 32'(enable_q);
        ADDR_PENDING: rdata_d = 32'(pending_q);
        ADDR_CLAIM:   rdata_d = 32'(claim_id);
        ADDR_TRIGGER: rdata_d = 32'(trigger_q);
        default:      rdata_d = '0;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_q  <= '0;
      trigger_q <= '0;
      pending_q <= '0;
      insvc_q   <= '0;
      rdata_q   <= '0;
      ext_irq_q <= 1'b0;
    end else begin
      enable_q  <= enable_d;
      trigger_q <= trigger_d;
      pending_q <= pending_d;
      insvc_q   <= insvc_d;
      rdata_q   <= rdata_d;
      ext_irq_q <= ext_irq_d;
    end
  end

  assign rdata   = rdata_q;
  assign ext_irq = ext_irq_q;

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Testbench for ext_irq_ctrl: directed steps from the feature list followed by
// randomized traffic, all checked against a behavioural reference model.
module tb_ext_irq_ctrl;

  localparam int unsigned N = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  irq_src;
  logic [3:0]    addr;
  logic          wr_en;
  logic          rd_en;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          ext_irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ext_irq_ctrl #(.NUM_SRC(N)) dut (
    .clk     (clk),
    .reset   (reset),
    .irq_src (irq_src),
    .addr    (addr),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .wdata   (wdata),
    .rdata   (rdata),
    .ext_irq (ext_irq)
  );

  // Reference model: sources are seen through a delay line of clock samples
  // (index 0 = newest); the synchronized view lags the pin by two samples.
  bit [N-1:0] m_en, m_trig, m_pend, m_isv;
  bit [N-1:0] m_line [3];
  bit [31:0]  m_rdata;
  bit         m_irq;

  function automatic void model_reset();
    m_en = '0; m_trig = '0; m_pend = '0; m_isv = '0;
    m_rdata = '0; m_irq = 1'b0;
    for (int k = 0; k < 3; k++) m_line[k] = '0;
  endfunction

  function automatic void model_step();
    bit [N-1:0] live, s, rose, pend_n, isv_n;
    int id;
    int c;
    bit claimed;
    live = m_pend & m_en;
    id = 0;
    for (int i = 0; i < int'(N); i++) if (id == 0 && live[i]) id = i + 1;
    s    = m_line[1];
    rose = m_line[1] & ~m_line[2];
    pend_n = m_pend;
    isv_n  = m_isv;
    if (rd_en) begin
      case (addr)
        4'h0:    m_rdata = 32'(m_en);
        4'h4:    m_rdata = 32'(m_pend);
        4'h8:    m_rdata = 32'(id);
        4'hC:    m_rdata = 32'(m_trig);
        default: m_rdata = 0;
      endcase
    end
    for (int i = 0; i < int'(N); i++) begin
      claimed = rd_en && addr == 4'h8 && id == i + 1;
      if (m_trig[i]) pend_n[i] = (m_pend[i] && !claimed) || rose[i];
      else           pend_n[i] = !m_isv[i] && s[i] && !claimed;
    end
    c = int'(wdata[4:0]);
    if (wr_en && addr == 4'h8 && c >= 1 && c <= int'(N)) isv_n[c-1] = 1'b0;
    if (rd_en && addr == 4'h8 && id != 0) isv_n[id-1] = 1'b1;
    if (wr_en && addr == 4'h0) m_en = wdata[N-1:0];
    if (wr_en && addr == 4'hC) m_trig = wdata[N-1:0];
    m_irq = (live != 0);
    m_line[2] = m_line[1];
    m_line[1] = m_line[0];
    m_line[0] = irq_src;
    m_pend = pend_n;
    m_isv  = isv_n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: model advances on the same edge, outputs compared 1 ns later
  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else       model_step();
    #1;
    chk("ext_irq", 32'(ext_irq), 32'(m_irq));
    chk("rdata", rdata, m_rdata);
    rd_en = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    addr = a; rd_en = 1'b1;
    tick();
    d = rdata;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] v);
    addr = a; wdata = v; wr_en = 1'b1;
    tick();
  endtask

  initial begin
    logic [31:0] d;
    int op;
    reset = 1'b1; irq_src = '0; addr = '0; wr_en = 1'b0; rd_en = 1'b0; wdata = '0;
    model_reset();
    idle(2);
    reset = 1'b0;

    // Reset then idle
    chk("rst_ext_irq", 32'(ext_irq), 0);
    rd(4'h0, d); chk("rst_enable", d, 0);
    rd(4'h4, d); chk("rst_pending", d, 0);
    rd(4'h8, d); chk("idle_claim", d, 0);
    rd(4'hC, d); chk("rst_trigger", d, 0);

    // Edge source 3 and its latency
    wr(4'hC, 32'h08);
    wr(4'h0, 32'h08);
    irq_src = 8'h08; tick();
    irq_src = 8'h00; tick(); tick();
    chk("lat_n2_low", 32'(ext_irq), 0);
    tick();
    chk("lat_n3_high", 32'(ext_irq), 1);
    rd(4'h8, d); chk("claim_src3", d, 4);
    rd(4'h4, d); chk("pend_after_claim3", d, 0);
    chk("irq_after_claim3", 32'(ext_irq), 0);
    wr(4'h8, 32'd4);

    // Priority between sources 2 and 5
    wr(4'hC, 32'h24);
    wr(4'h0, 32'hFF);
    irq_src = 8'h24; tick();
    irq_src = 8'h00; idle(3);
    chk("prio_irq", 32'(ext_irq), 1);
    rd(4'h8, d); chk("prio_first", d, 3);
    rd(4'h8, d); chk("prio_second", d, 6);
    tick();
    chk("prio_irq_drop", 32'(ext_irq), 0);
    wr(4'h8, 32'd3);
    wr(4'h8, 32'd6);

    // Level source 1
    wr(4'hC, 32'h00);
    wr(4'h0, 32'h02);
    irq_src = 8'h02; idle(4);
    chk("lvl_irq", 32'(ext_irq), 1);
    rd(4'h8, d); chk("lvl_claim", d, 2);
    idle(2);
    rd(4'h4, d); chk("lvl_pend_in_svc", d, 0);
    wr(4'h8, 32'd2);
    tick();
    rd(4'h4, d); chk("lvl_pend_reassert", d, 32'h02);
    chk("lvl_irq_again", 32'(ext_irq), 1);
    irq_src = 8'h00; idle(4);
    rd(4'h4, d); chk("lvl_pend_released", d, 0);

    // Edge during service: one queued event
    wr(4'hC, 32'h01);
    wr(4'h0, 32'h01);
    irq_src = 8'h01; tick();
    irq_src = 8'h00; idle(3);
    rd(4'h8, d); chk("svc_claim1", d, 1);
    irq_src = 8'h01; tick();
    irq_src = 8'h00; tick();
    irq_src = 8'h01; tick();
    irq_src = 8'h00; tick();
    idle(3);
    rd(4'h4, d); chk("svc_queued", d, 32'h01);
    rd(4'h8, d); chk("svc_claim2", d, 1);

    // Illegal completes leave source 0 in service (level, line held high)
    wr(4'hC, 32'h00);
    irq_src = 8'h01; idle(4);
    rd(4'h4, d); chk("ill_pend_before", d, 0);
    wr(4'h8, 32'd0);
    wr(4'h8, 32'd9);
    wr(4'h8, 32'd3);
    idle(2);
    rd(4'h4, d); chk("ill_pend_after", d, 0);
    wr(4'h8, 32'd1);
    idle(2);
    chk("legal_cmp_irq", 32'(ext_irq), 1);
    rd(4'h4, d); chk("legal_cmp_pend", d, 32'h01);

    // Asynchronous reset while ext_irq is high
    tick();
    #2 reset = 1'b1;
    #1;
    chk("async_rst_irq", 32'(ext_irq), 0);
    chk("async_rst_rdata", rdata, 0);
    model_reset();
    irq_src = 8'h00;
    tick();
    reset = 1'b0;
    rd(4'h0, d); chk("post_rst_enable", d, 0);
    rd(4'hC, d); chk("post_rst_trigger", d, 0);
    rd(4'h4, d); chk("post_rst_pending", d, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      for (int b = 0; b < int'(N); b++) if ($urandom_range(0, 7) == 0) irq_src[b] = ~irq_src[b];
      op = $urandom_range(0, 19);
      case (op)
        0, 1, 2: begin addr = 4'($urandom_range(0, 15)); rd_en = 1'b1; end
        3, 4, 5: begin addr = 4'h8; rd_en = 1'b1; end
        6:       begin addr = 4'h0; wdata = $urandom; wr_en = 1'b1; end
        7:       begin addr = 4'hC; wdata = $urandom; wr_en = 1'b1; end
        8, 9:    begin addr = 4'h8; wdata = 32'($urandom_range(0, 10)); wr_en = 1'b1; end
        10:      begin addr = 4'h8; wdata = 32'($urandom_range(0, 10)); wr_en = 1'b1; rd_en = 1'b1; end
        11:      begin addr = 4'h4; wdata = $urandom; wr_en = 1'b1; rd_en = 1'b1; end
        12:      begin addr = 4'($urandom_range(0, 15)); wdata = $urandom; wr_en = 1'b1; end
        default: ;
      endcase
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
